// File: rtl/weight_feed_pkg.sv
// weight_feed_pkg: feeder state encoding, default lane geometry and skid FIFO entry width
package weight_feed_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FULL, STREAM, DRAIN} state_e;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LANE_WIDTH = 8;
  localparam int DEF_LANES = 8;
  localparam int ENTRY_WIDTH = DEF_DATA_WIDTH + 2;
endpackage

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo: power-of-two skid FIFO (push/din, pop, valid/dout head gated to zero when empty, occupancy count)
module weight_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop & valid;
  assign dout = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/weight_lane_feeder.sv
// weight_lane_feeder: streams a tile of weight words from the buffer (start/word_count, buf_full/buf_rd_en/buf_dout/buf_out_next) to the PE lanes (w_valid/w_ready/w_data/w_last/w_tile_next) with busy/done/err_underrun status
module weight_lane_feeder
  import weight_feed_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [10:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underrun,
  input  logic                  buf_full,
  output logic                  buf_rd_en,
  input  logic [DATA_WIDTH-1:0] buf_dout,
  input  logic                  buf_out_next,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last,
  output logic                  w_tile_next
);
  localparam int EW = ENTRY_WIDTH - DEF_DATA_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state, state_nx;
  logic [10:0] wc, issued;
  logic inflight, last_d, next_d, accept, pop;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] head;
  assign accept = state == IDLE && start;
  assign pop = w_valid && w_ready;
  assign busy = state != IDLE;
  assign w_tile_next = head[EW-1];
  assign w_last = head[EW-2];
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_data[k*LANE_WIDTH +: LANE_WIDTH] = head[k*LANE_WIDTH +: LANE_WIDTH];
  end
  always_comb buf_rd_en = state == STREAM && buf_full && issued < wc &&
                          (fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start && word_count != 11'd0 ? WAIT_FULL : IDLE;
      WAIT_FULL: state_nx = buf_full ? STREAM : WAIT_FULL;
      STREAM:    state_nx = issued == wc ? DRAIN : STREAM;
      DRAIN:     state_nx = pop && w_last ? IDLE : DRAIN;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wc <= '0;
      issued <= '0;
      inflight <= 1'b0;
      last_d <= 1'b0;
      next_d <= 1'b0;
      done <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= buf_rd_en;
      last_d <= buf_rd_en && issued == wc - 11'd1;
      next_d <= buf_rd_en && buf_out_next;
      done <= (accept && word_count == 11'd0) || (state == DRAIN && pop && w_last);
      if (accept) begin
        wc <= word_count;
        issued <= '0;
        err_underrun <= 1'b0;
      end else begin
        if (buf_rd_en) issued <= issued + 11'd1;
        if (state == STREAM && !buf_full && issued < wc) err_underrun <= 1'b1;
      end
    end
  end
  weight_skid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .din({next_d, last_d, buf_dout}),
    .pop(pop),
    .dout(head),
    .valid(w_valid),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_weight_lane_feeder.sv
// tb_weight_lane_feeder: randomized bench with a queue-based model of the weight lane feeder
module tb_weight_lane_feeder;
  logic clk, rst, start, buf_full, w_ready;
  logic [10:0] word_count;
  logic busy, done, err_underrun, buf_rd_en, w_valid, w_last, w_tile_next, buf_out_next;
  logic [63:0] buf_dout, w_data;
  weight_lane_feeder dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .busy(busy), .done(done),
    .err_underrun(err_underrun), .buf_full(buf_full), .buf_rd_en(buf_rd_en), .buf_dout(buf_dout),
    .buf_out_next(buf_out_next), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_last(w_last), .w_tile_next(w_tile_next)
  );
  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] mem [16];
  int marker_idx = -1, rd_idx = 0, mode = 0, ph = 0;
  logic [3:0] pat = 4'b1001;
  logic br, bs;
  logic [65:0] expq[$];
  logic model_busy = 0, exp_done = 0, exp_err = 0, in_stream = 0, stalled = 0, acc, hs;
  logic [63:0] held;
  int cur_wc = 0, rd_total = 0, hs_total = 0, t0 = 0;
  int first_rd = -1, last_rd = -1, first_v = -1, last_v = -1, done_rel = -1, n_rd = 0, n_hs = 0, tn_pos = -1, tn_cnt = 0;
  assign buf_out_next = rd_idx == marker_idx;
  task automatic chk(string nm, logic [65:0] act, logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic start_tile(int n);
    tick();
    start = 1'b1;
    word_count = 11'(n);
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(int lim);
    int k;
    for (k = 0; k < lim && done_rel < 0; k++) tick();
    if (done_rel < 0) fail("done_timeout");
    tick();
    chk("queue_drained", 66'(expq.size()), 66'd0);
  endtask
  task automatic fill(bit addr_pat);
    for (int i = 0; i < 16; i++) mem[i] = addr_pat ? 64'(i) : {$urandom, $urandom};
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    buf_dout = '0;
    forever begin
      @(negedge clk);
      br = buf_rd_en;
      bs = rst || (start && !busy);
      @(posedge clk);
      #1;
      if (bs) rd_idx = 0;
      else if (br) begin
        buf_dout = mem[rd_idx % 16];
        rd_idx++;
      end
    end
  end
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      w_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[ph % 4] : 1'($urandom % 2);
      ph++;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      model_busy = 0; exp_done = 0; exp_err = 0; in_stream = 0; stalled = 0;
      rd_total = 0; hs_total = 0;
    end else begin
      acc = start && !model_busy;
      chk("done", 66'(done), 66'(exp_done));
      chk("busy", 66'(busy), 66'(model_busy));
      chk("err_underrun", 66'(err_underrun), 66'(exp_err));
      if (done) done_rel = cyc - t0;
      if (buf_rd_en) begin
        chk("credit", 66'(rd_total - hs_total < 4), 66'd1);
        chk("rd_needs_full", 66'(buf_full), 66'd1);
        chk("rd_in_range", 66'(model_busy && rd_total < cur_wc), 66'd1);
      end
      if (stalled) chk("stall_hold", {1'b1, w_valid, w_data}, {2'b11, held});
      if (w_valid) begin
        if (expq.size() == 0) fail("spurious_valid");
        else chk("word", {w_tile_next, w_last, w_data}, expq[0]);
        if (first_v < 0) first_v = cyc - t0;
        last_v = cyc - t0;
      end
      if (model_busy && in_stream && !buf_full && rd_total < cur_wc) exp_err = 1;
      if (model_busy && buf_full) in_stream = 1;
      if (buf_rd_en) begin
        if (first_rd < 0) first_rd = cyc - t0;
        last_rd = cyc - t0;
        n_rd++;
        rd_total++;
      end
      hs = w_valid && w_ready;
      exp_done = 0;
      if (hs) begin
        if (w_tile_next) begin tn_pos = n_hs; tn_cnt++; end
        if (expq.size() > 0) begin
          exp_done = expq[0][64];
          if (exp_done) model_busy = 0;
          void'(expq.pop_front());
        end
        n_hs++;
        hs_total++;
      end
      stalled = w_valid && !w_ready;
      held = w_data;
      if (acc) begin
        exp_err = 0; t0 = cyc;
        first_rd = -1; last_rd = -1; first_v = -1; last_v = -1; done_rel = -1;
        n_rd = 0; n_hs = 0; tn_pos = -1; tn_cnt = 0;
        if (word_count == 0) exp_done = 1;
        else begin
          model_busy = 1; in_stream = 0; cur_wc = int'(word_count);
          rd_total = 0; hs_total = 0;
          for (int i = 0; i < cur_wc; i++) expq.push_back({i == marker_idx, i == cur_wc - 1, mem[i]});
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, n;
    rst = 1; start = 0; word_count = '0; buf_full = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst_busy", 66'(busy), 0); chk("rst_done", 66'(done), 0);
    chk("rst_err", 66'(err_underrun), 0); chk("rst_rd_en", 66'(buf_rd_en), 0);
    chk("rst_valid", 66'(w_valid), 0); chk("rst_last", 66'(w_last), 0);
    chk("rst_tile_next", 66'(w_tile_next), 0); chk("rst_data", 66'(w_data), 0);
    // basic stream with address-pattern data
    fill(1); buf_full = 1; mode = 0;
    start_tile(6); wait_done(40);
    chk("basic_first_rd", 66'(first_rd), 2); chk("basic_last_rd", 66'(last_rd), 7);
    chk("basic_first_valid", 66'(first_v), 4); chk("basic_last_valid", 66'(last_v), 9);
    chk("basic_done_cycle", 66'(done_rel), 10); chk("basic_reads", 66'(n_rd), 6);
    // backpressure 1,0,0,1
    fill(0); mode = 1;
    start_tile(10); wait_done(100);
    chk("bp_words", 66'(n_hs), 10);
    // tile marker on 3rd read
    fill(0); mode = 2; marker_idx = 2;
    start_tile(5); wait_done(100);
    chk("marker_pos", 66'(tn_pos), 2); chk("marker_count", 66'(tn_cnt), 1);
    marker_idx = -1;
    // zero count
    mode = 0;
    start_tile(0); wait_done(10);
    chk("zero_done_cycle", 66'(done_rel), 1); chk("zero_reads", 66'(n_rd), 0);
    // late full
    fill(0); buf_full = 0;
    start_tile(4);
    repeat (5) tick();
    chk("late_no_read", 66'(n_rd), 0);
    buf_full = 1; wait_done(60);
    chk("late_words", 66'(n_hs), 4);
    // underrun
    fill(0);
    start_tile(8);
    for (k = 0; k < 30 && n_rd < 3; k++) tick();
    if (n_rd < 3) fail("underrun_wait");
    buf_full = 0; n = n_rd;
    repeat (3) tick();
    chk("underrun_paused", 66'(n_rd), 66'(n)); chk("underrun_flag", 66'(err_underrun), 1);
    buf_full = 1; wait_done(60);
    chk("underrun_sticky", 66'(err_underrun), 1); chk("underrun_words", 66'(n_hs), 8);
    // reset mid-stream
    fill(0);
    start_tile(8);
    for (k = 0; k < 30 && n_hs < 3; k++) tick();
    if (n_hs < 3) fail("reset_wait");
    rst = 1; tick(); rst = 0;
    chk("mid_rst_busy", 66'(busy), 0); chk("mid_rst_valid", 66'(w_valid), 0);
    chk("mid_rst_rd_en", 66'(buf_rd_en), 0); chk("mid_rst_data", 66'(w_data), 0);
    chk("mid_rst_last", 66'(w_last), 0); chk("mid_rst_err", 66'(err_underrun), 0);
    repeat (2) tick();
    fill(0); start_tile(2); wait_done(40);
    chk("post_rst_words", 66'(n_hs), 2);
    // random tiles with stray start, random ready and short buf_full drops
    for (int t = 0; t < 8; t++) begin
      fill(0); mode = 2;
      n = $urandom_range(1, 12);
      marker_idx = $urandom_range(0, n - 1);
      start_tile(n);
      tick();
      start = 1; word_count = 11'($urandom_range(1, 15)); tick(); start = 0;
      buf_full = 0; repeat ($urandom_range(0, 2)) tick(); buf_full = 1;
      wait_done(200);
      chk("rand_words", 66'(n_hs), 66'(n));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
